// File: rtl/meu_fifo_arb_if.sv
// Bus bundle for meu_fifo_arb: requester write port, FIFO side, consumer side and flush control.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface meu_fifo_arb_if #(
  parameter int NREQ = 4,
  parameter int DW   = 47
);
  logic [NREQ-1:0]    i_req_valid;
  logic [NREQ*DW-1:0] i_req_data;
  logic [NREQ-1:0]    o_req_ready;
  logic               o_fifo_wr_en;
  logic [DW-1:0]      o_fifo_wr_data;
  logic               i_fifo_full;
  logic               o_fifo_rd;
  logic [DW-1:0]      i_fifo_rd_data;
  logic               i_fifo_empty;
  logic               o_out_valid;
  logic [DW-1:0]      o_out_data;
  logic               i_out_ready;
  logic               i_flush;
  logic               o_flushing;
  logic               o_flush_done;

  modport slave (
    input  i_req_valid, i_req_data, i_fifo_full, i_fifo_rd_data, i_fifo_empty,
           i_out_ready, i_flush,
    output o_req_ready, o_fifo_wr_en, o_fifo_wr_data, o_fifo_rd, o_out_valid,
           o_out_data, o_flushing, o_flush_done
  );

  modport master (
    output i_req_valid, i_req_data, i_fifo_full, i_fifo_rd_data, i_fifo_empty,
           i_out_ready, i_flush,
    input  o_req_ready, o_fifo_wr_en, o_fifo_wr_data, o_fifo_rd, o_out_valid,
           o_out_data, o_flushing, o_flush_done
  );
endinterface

// File: rtl/meu_fifo_arb.sv
// Round-robin write arbiter plus read/flush sequencer for one MEU FIFO; zero-latency grant and pop.
// Grants stall while full or flushing; DRAIN discards every queued entry, then pulses flush_done.
module meu_fifo_arb #(
  parameter int NREQ = 4,
  parameter int DW   = 47
) (
  input  logic          i_clk,
  input  logic          i_reset,
  meu_fifo_arb_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_e;

  state_e        state_q;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic          flush_done_q;

  logic            arb_ok;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   gnt_idx;
  logic            found;
  logic [PW:0]     idx;
  logic            wr_en;
  logic            out_valid;

  assign arb_ok = (state_q == IDLE) & ~bus.i_flush & ~bus.i_fifo_full & ~i_reset;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    if (arb_ok) begin
      for (int i = 0; i < NREQ; i++) begin
        idx = {1'b0, rr_ptr_q} + (PW+1)'(i);
        if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
        if (!found && bus.i_req_valid[idx[PW-1:0]]) begin
          found   = 1'b1;
          gnt_idx = idx[PW-1:0];
        end
      end
      grant[gnt_idx] = found;
    end
  end

  assign wr_en              = |(grant & bus.i_req_valid);
  assign bus.o_req_ready    = grant;
  assign bus.o_fifo_wr_en   = wr_en;
  assign bus.o_fifo_wr_data = wr_en ? bus.i_req_data[gnt_idx*DW +: DW] : '0;

  assign rr_ptr_d = !wr_en                       ? rr_ptr_q :
                    (gnt_idx == PW'(NREQ - 1))   ? '0       :
                                                   gnt_idx + PW'(1);

  // Drained entries are popped but never shown to the consumer.
  assign out_valid        = (state_q == IDLE) & ~bus.i_fifo_empty & ~i_reset;
  assign bus.o_out_valid  = out_valid;
  assign bus.o_out_data   = bus.i_fifo_rd_data;
  assign bus.o_fifo_rd    = ~i_reset & ((out_valid & bus.i_out_ready) |
                                        ((state_q == DRAIN) & ~bus.i_fifo_empty));
  assign bus.o_flushing   = (state_q == DRAIN);
  assign bus.o_flush_done = flush_done_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      flush_done_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      flush_done_q <= 1'b0;
      case (state_q)
        IDLE:  if (bus.i_flush) state_q <= DRAIN;
        DRAIN: if (bus.i_fifo_empty) begin
          state_q      <= IDLE;
          flush_done_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_meu_fifo_arb.sv
// Directed bench for meu_fifo_arb with a behavioural FIFO and a scoreboard monitor.
module tb_meu_fifo_arb;
  localparam int NREQ = 4;
  localparam int DW   = 47;
  localparam logic [DW-1:0] BASE  = 47'h0A5A_F00D_0000;
  localparam logic [DW-1:0] DAT_A = 47'h1111_2222_3333;
  localparam logic [DW-1:0] DAT_B = 47'h0444_5555_6666;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  meu_fifo_arb_if #(.NREQ(NREQ), .DW(DW)) bus();
  meu_fifo_arb #(.NREQ(NREQ), .DW(DW)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_wr[$];
  logic [DW-1:0] exp_out[$];

  // Behavioural circular FIFO with run-time depth.
  logic [DW-1:0] mem [16];
  int head = 0, tail = 0, count = 0, depth = 8;
  always @(posedge clk) begin
    if (rst) begin
      head <= 0; tail <= 0; count <= 0;
    end else begin
      if (bus.o_fifo_wr_en) begin
        mem[tail] <= bus.o_fifo_wr_data;
        tail      <= (tail + 1) % 16;
      end
      if (bus.o_fifo_rd) head <= (head + 1) % 16;
      count <= count + (bus.o_fifo_wr_en ? 1 : 0) - (bus.o_fifo_rd ? 1 : 0);
    end
  end
  always_comb begin
    bus.i_fifo_empty   = (count == 0);
    bus.i_fifo_full    = (count >= depth);
    bus.i_fifo_rd_data = mem[head];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every write and every consumer pop is matched against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      chk("no_overflow", 64'(bus.o_fifo_wr_en & bus.i_fifo_full), 64'(0));
      chk("no_underflow", 64'(bus.o_fifo_rd & bus.i_fifo_empty), 64'(0));
      chk("ready_onehot", 64'($countones(bus.o_req_ready) <= 1), 64'(1));
      chk("wr_en_vs_grant", 64'(bus.o_fifo_wr_en), 64'(|(bus.o_req_ready & bus.i_req_valid)));
      if (bus.o_fifo_wr_en) begin
        if (exp_wr.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_write: got %0h expected none at %0t", bus.o_fifo_wr_data, $time);
        end else chk("wr_data", 64'(bus.o_fifo_wr_data), 64'(exp_wr.pop_front()));
      end
      if (bus.o_out_valid && bus.i_out_ready) begin
        if (exp_out.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_out: got %0h expected none at %0t", bus.o_out_data, $time);
        end else chk("out_data", 64'(bus.o_out_data), 64'(exp_out.pop_front()));
      end
    end
  end

  function automatic logic [DW-1:0] dat(input int k);
    return BASE + DW'(k);
  endfunction

  task automatic nxt(); @(posedge clk); #1; endtask
  task automatic mid(); @(negedge clk); endtask

  task automatic set_data();
    for (int k = 0; k < NREQ; k++) bus.i_req_data[k*DW +: DW] = dat(k);
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.i_req_valid = '1; bus.i_out_ready = 1'b1; bus.i_flush = 1'b0;
    nxt(); mid();
    chk("rst_ready", 64'(bus.o_req_ready), 64'(0));
    chk("rst_wr_en", 64'(bus.o_fifo_wr_en), 64'(0));
    chk("rst_fifo_rd", 64'(bus.o_fifo_rd), 64'(0));
    chk("rst_out_valid", 64'(bus.o_out_valid), 64'(0));
    chk("rst_flushing", 64'(bus.o_flushing), 64'(0));
    chk("rst_done", 64'(bus.o_flush_done), 64'(0));
    nxt();
    rst = 1'b0; bus.i_req_valid = '0; bus.i_out_ready = 1'b0;
  endtask

  task automatic drain_out();
    int t;
    t = 0;
    bus.i_out_ready = 1'b1;
    mid();
    while (!bus.i_fifo_empty && t < 40) begin nxt(); mid(); t++; end
    chk("drain_in_time", 64'(t < 40), 64'(1));
    nxt();
    bus.i_out_ready = 1'b0;
  endtask

  task automatic qcheck(input string name);
    chk({name, "_wr_left"}, 64'(exp_wr.size()), 64'(0));
    chk({name, "_out_left"}, 64'(exp_out.size()), 64'(0));
    exp_wr.delete(); exp_out.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] rdy_seq;
    bus.i_req_valid = '0; bus.i_out_ready = 1'b0; bus.i_flush = 1'b0;
    set_data();

    // Single requester held valid, then the pointer must sit just past it.
    do_reset(); depth = 8;
    bus.i_req_valid = 4'b0100;
    repeat (3) begin
      exp_wr.push_back(dat(2)); mid();
      chk("t1_ready", 64'(bus.o_req_ready), 64'(4'b0100)); nxt();
    end
    bus.i_req_valid = '1; exp_wr.push_back(dat(3)); mid();
    chk("t1_rr_ptr3", 64'(bus.o_req_ready), 64'(4'b1000)); nxt();
    bus.i_req_valid = '0;
    exp_out.push_back(dat(2)); exp_out.push_back(dat(2));
    exp_out.push_back(dat(2)); exp_out.push_back(dat(3));
    drain_out(); qcheck("t1");

    // All requesters valid: strict rotation 0,1,2,3,0,1.
    do_reset(); depth = 16;
    bus.i_req_valid = '1;
    for (int i = 0; i < 6; i++) begin
      exp_wr.push_back(dat(i % 4)); exp_out.push_back(dat(i % 4)); mid();
      chk("t2_grant", 64'(bus.o_req_ready), 64'(1) << (i % 4)); nxt();
    end
    bus.i_req_valid = '0;
    drain_out(); qcheck("t2");

    // Full backpressure with depth 4.
    do_reset(); depth = 4;
    bus.i_req_valid = '1;
    for (int k = 0; k < 4; k++) begin
      exp_wr.push_back(dat(k)); mid();
      chk("t3_grant", 64'(bus.o_req_ready), 64'(1) << k); nxt();
    end
    repeat (2) begin
      mid();
      chk("t3_full_ready", 64'(bus.o_req_ready), 64'(0));
      chk("t3_full_wr", 64'(bus.o_fifo_wr_en), 64'(0)); nxt();
    end
    bus.i_out_ready = 1'b1; exp_out.push_back(dat(0)); mid();
    chk("t3_pop", 64'(bus.o_fifo_rd), 64'(1));
    chk("t3_pop_ready", 64'(bus.o_req_ready), 64'(0)); nxt();
    bus.i_out_ready = 1'b0; exp_wr.push_back(dat(0)); mid();
    chk("t3_refill", 64'(bus.o_req_ready), 64'(4'b0001)); nxt();
    mid(); chk("t3_full_again", 64'(bus.o_req_ready), 64'(0)); nxt();
    bus.i_req_valid = '0;
    exp_out.push_back(dat(1)); exp_out.push_back(dat(2));
    exp_out.push_back(dat(3)); exp_out.push_back(dat(0));
    drain_out(); qcheck("t3");

    // Consumer handshake with ready toggling 0,1,0,1.
    do_reset(); depth = 8;
    bus.i_req_valid = 4'b0001;
    bus.i_req_data[0 +: DW] = DAT_A; exp_wr.push_back(DAT_A); mid(); nxt();
    bus.i_req_data[0 +: DW] = DAT_B; exp_wr.push_back(DAT_B); mid(); nxt();
    bus.i_req_valid = '0; set_data();
    exp_out.push_back(DAT_A); exp_out.push_back(DAT_B);
    rdy_seq = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      bus.i_out_ready = rdy_seq[i]; mid();
      chk("t4_valid", 64'(bus.o_out_valid), 64'(1));
      chk("t4_data", 64'(bus.o_out_data), 64'((i < 2) ? DAT_A : DAT_B));
      chk("t4_rd", 64'(bus.o_fifo_rd), 64'(rdy_seq[i])); nxt();
    end
    bus.i_out_ready = 1'b0; mid();
    chk("t4_valid_after", 64'(bus.o_out_valid), 64'(0)); nxt();
    qcheck("t4");

    // Flush with three entries queued and requesters still valid.
    do_reset(); depth = 8;
    bus.i_req_valid = '1;
    for (int k = 0; k < 3; k++) begin
      exp_wr.push_back(dat(k)); mid();
      chk("t5_fill", 64'(bus.o_req_ready), 64'(1) << k); nxt();
    end
    bus.i_flush = 1'b1; mid();
    chk("t5_flush_cycle_ready", 64'(bus.o_req_ready), 64'(0));
    chk("t5_flush_cycle_flushing", 64'(bus.o_flushing), 64'(0)); nxt();
    bus.i_flush = 1'b0; bus.i_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("t5_flushing", 64'(bus.o_flushing), 64'(1));
      chk("t5_drain_ready", 64'(bus.o_req_ready), 64'(0));
      chk("t5_drain_valid", 64'(bus.o_out_valid), 64'(0));
      chk("t5_drain_rd", 64'(bus.o_fifo_rd), 64'(i < 3));
      chk("t5_drain_done", 64'(bus.o_flush_done), 64'(0)); nxt();
    end
    exp_wr.push_back(dat(3)); mid();
    chk("t5_end_flushing", 64'(bus.o_flushing), 64'(0));
    chk("t5_done", 64'(bus.o_flush_done), 64'(1));
    chk("t5_resume", 64'(bus.o_req_ready), 64'(4'b1000)); nxt();
    bus.i_req_valid = '0; exp_out.push_back(dat(3)); mid();
    chk("t5_done_once", 64'(bus.o_flush_done), 64'(0)); nxt();
    bus.i_out_ready = 1'b0; bus.i_flush = 1'b1; mid(); nxt();
    bus.i_flush = 1'b0; mid();
    chk("t5_empty_flushing", 64'(bus.o_flushing), 64'(1));
    chk("t5_empty_rd", 64'(bus.o_fifo_rd), 64'(0)); nxt();
    mid();
    chk("t5_empty_end", 64'(bus.o_flushing), 64'(0));
    chk("t5_empty_done", 64'(bus.o_flush_done), 64'(1)); nxt();
    mid(); chk("t5_empty_done_off", 64'(bus.o_flush_done), 64'(0)); nxt();
    qcheck("t5");

    // Second flush during DRAIN is ignored.
    do_reset(); depth = 8;
    bus.i_req_valid = '1;
    exp_wr.push_back(dat(0)); mid(); nxt();
    exp_wr.push_back(dat(1)); mid(); nxt();
    bus.i_req_valid = '0; bus.i_flush = 1'b1; mid(); nxt();
    mid();
    chk("t6_d1_flushing", 64'(bus.o_flushing), 64'(1));
    chk("t6_d1_rd", 64'(bus.o_fifo_rd), 64'(1)); nxt();
    bus.i_flush = 1'b0; mid();
    chk("t6_d2_rd", 64'(bus.o_fifo_rd), 64'(1));
    chk("t6_d2_done", 64'(bus.o_flush_done), 64'(0)); nxt();
    mid();
    chk("t6_d3_flushing", 64'(bus.o_flushing), 64'(1));
    chk("t6_d3_rd", 64'(bus.o_fifo_rd), 64'(0)); nxt();
    mid();
    chk("t6_done", 64'(bus.o_flush_done), 64'(1));
    chk("t6_idle", 64'(bus.o_flushing), 64'(0)); nxt();
    mid();
    chk("t6_no_second_done", 64'(bus.o_flush_done), 64'(0));
    chk("t6_no_restart", 64'(bus.o_flushing), 64'(0)); nxt();
    qcheck("t6");

    // Reset asserted mid-DRAIN.
    do_reset(); depth = 8;
    bus.i_req_valid = '1;
    for (int k = 0; k < 3; k++) begin exp_wr.push_back(dat(k)); mid(); nxt(); end
    bus.i_req_valid = '0; bus.i_flush = 1'b1; mid(); nxt();
    bus.i_flush = 1'b0; mid();
    chk("t7_in_drain", 64'(bus.o_flushing), 64'(1)); nxt();
    rst = 1'b1; bus.i_req_valid = '1; mid();
    chk("t7_rst_rd", 64'(bus.o_fifo_rd), 64'(0));
    chk("t7_rst_ready", 64'(bus.o_req_ready), 64'(0)); nxt();
    rst = 1'b0; exp_wr.push_back(dat(0)); mid();
    chk("t7_flushing", 64'(bus.o_flushing), 64'(0));
    chk("t7_no_done", 64'(bus.o_flush_done), 64'(0));
    chk("t7_rr_ptr0", 64'(bus.o_req_ready), 64'(4'b0001)); nxt();
    bus.i_req_valid = '0; mid();
    chk("t7_still_no_done", 64'(bus.o_flush_done), 64'(0)); nxt();
    exp_out.push_back(dat(0));
    drain_out(); qcheck("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/meu_fifo_arb.md
Name: meu_fifo_arb

Overview:
- Round-robin write arbiter and read/flush sequencer for one circular-buffer FIFO in the MEU.
- Lets NREQ producers (e.g. AGU lanes) share the FIFO's single write port.
- Presents the FIFO head to one consumer with a valid/ready handshake.
- Drains the FIFO completely when a flush is requested.

Parameters:
- NREQ, 4, number of write requesters (2..8).
- DW, 47, entry data width; must match the FIFO's DW.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_req_valid  in  NREQ  per-requester write request.
- i_req_data  in  NREQ*DW  requester k's data is at bits [k*DW +: DW].
- o_req_ready  out  NREQ  one-hot grant; a transfer occurs when valid[k] & ready[k].
- o_fifo_wr_en  out  1  FIFO write enable.
- o_fifo_wr_data  out  DW  FIFO write data.
- i_fifo_full  in  1  FIFO full.
- o_fifo_rd  out  1  FIFO pop.
- i_fifo_rd_data  in  DW  FIFO head data; combinational, valid while not empty.
- i_fifo_empty  in  1  FIFO empty.
- o_out_valid  out  1  head entry available to the consumer.
- o_out_data  out  DW  head entry.
- i_out_ready  in  1  consumer accepts the head.
- i_flush  in  1  one-cycle flush request.
- o_flushing  out  1  high while in DRAIN.
- o_flush_done  out  1  one-cycle pulse when the drain completes.

Behaviour:
- Reset values:
  - state=IDLE; rr_ptr=0.
  - o_flush_done=0, o_flushing=0.
  - All combinational outputs are 0 while i_reset is high: o_req_ready, o_fifo_wr_en, o_fifo_rd, o_out_valid.
- State machine, registered, two states:
  - IDLE -> DRAIN when i_flush=1.
  - DRAIN -> IDLE when i_fifo_empty=1; o_flush_done is registered high for exactly the next cycle.
  - i_flush while already in DRAIN is ignored. No second done pulse is generated.
- Write arbitration:
  - Combinational grant, zero-latency write.
  - Eligible only when state==IDLE, i_flush==0, i_fifo_full==0 and ~i_reset.
  - Search starts at index rr_ptr and wraps modulo NREQ. The first k with i_req_valid[k]=1 receives o_req_ready[k]=1; all other ready bits are 0.
  - o_fifo_wr_en = |(o_req_ready & i_req_valid).
  - o_fifo_wr_data = i_req_data of the granted index. Don't-care when wr_en=0; drive 0.
  - rr_ptr <= granted index+1 (mod NREQ) only on a completed transfer; otherwise it holds.
  - A single requester held valid gets a grant every cycle.
  - No requester waits more than NREQ-1 transfers while held valid.
  - Full: no ready bits, rr_ptr stable, no write.
- Read side:
  - o_out_valid = (state==IDLE) & ~i_fifo_empty.
  - o_out_data = i_fifo_rd_data.
  - o_fifo_rd = (o_out_valid & i_out_ready) | ((state==DRAIN) & ~i_fifo_empty).
  - In DRAIN, o_out_valid=0: drained entries are discarded and never delivered to the consumer.
  - Empty FIFO: o_fifo_rd is never asserted (no underflow pops).
  - A write and a read in the same cycle are both allowed. A write when full is never issued.
- Flush cycle:
  - In the cycle i_flush=1 (IDLE), no grant is issued.
  - A consumer pop in that cycle is still allowed (o_out_valid unaffected by i_flush).
- o_flushing = (state==DRAIN).
- Drain duration: N cycles for N entries, plus 1 cycle to observe empty.
- Reset mid-DRAIN: returns to IDLE with no o_flush_done pulse. The FIFO is reset separately by the same i_reset.

Test Plan:
- Single requester: NREQ=4, req_valid=4'b0100 for 3 cycles, FIFO empty.
  - Expect ready=4'b0100 each cycle and 3 writes.
  - rr_ptr ends at 3.
- All four requesters valid continuously from reset, FIFO never full.
  - Expect grant order 0,1,2,3,0,1.
  - o_fifo_wr_data equals each winner's data, e.g. tag k in the low bits.
- Full backpressure: FIFO depth 4, consumer ready=0, all requesters valid.
  - Exactly 4 writes, then ready=0 while full.
  - Set consumer ready=1 for 1 cycle: one pop, and next cycle exactly one grant to the next round-robin index.
- Consumer handshake: write A, B; i_out_ready toggles 0,1,0,1.
  - out_data=A is held while ready=0.
  - Pops occur only on ready=1 cycles; order A then B; o_out_valid=0 after B.
- Flush with 3 entries queued, requesters valid.
  - Expect no grants from the flush cycle onward.
  - o_flushing=1 for 4 cycles and o_fifo_rd=1 for 3 cycles; o_out_valid=0 throughout.
  - o_flush_done pulses once, then grants resume.
  - Flush on an empty FIFO yields o_flushing for 1 cycle, then done.
- Reset asserted during DRAIN.
  - Next cycle state=IDLE, o_flushing=0, no o_flush_done pulse, rr_ptr=0.
  - Second i_flush during DRAIN produces no extra pulse.
